display_mux_n: RTL



---
 rtl/display_mux_n.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/display_mux_n.sv
// Multiplexed seven-segment scan driver (1..8 digits) with buffered loading, LZ blanking, PWM dimming.
// Outputs registered, 1-cycle latency; no backpressure: load is always accepted, last load in a frame wins.
module display_mux_n #(
    parameter int DIGITS        = 8,
    parameter int PRESCALE_LOG2 = 11,
    parameter int BRIGHT_W      = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     point,
    input  logic                  load,
    input  logic                  blank_lz,
    input  logic [BRIGHT_W-1:0]   brightness,
    output logic [7:0]            segment,
    output logic [7:0]            digit,
    output logic                  frame_done
);

    localparam int SLOT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(DIGITS - 1);

    logic [PRESCALE_LOG2-1:0] presc_q, presc_d;
    logic [SLOT_W-1:0]        slot_q, slot_d;
    logic                     frame_done_q, frame_done_d;
    logic [4*DIGITS-1:0]      stage_val_q, stage_val_d;
    logic [DIGITS-1:0]        stage_pt_q, stage_pt_d;
    logic                     pending_q, pending_d;
    logic [4*DIGITS-1:0]      shadow_val_q, shadow_val_d;
    logic [DIGITS-1:0]        shadow_pt_q, shadow_pt_d;
    logic [7:0]               segment_q, segment_d;
    logic [7:0]               digit_q, digit_d;

    logic                     presc_wrap;
    logic                     boundary;
    logic [DIGITS-1:0]        upper_zero;
    logic                     zero_acc;
    logic [3:0]               nibble;
    logic                     blank;
    logic                     lit;
    logic [BRIGHT_W-1:0]      presc_top;

    // Active-high {a,b,c,d,e,f,g}
    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0:    hex7 = 7'b1111110;
            4'h1:    hex7 = 7'b0110000;
            4'h2:    hex7 = 7'b1101101;
            4'h3:    hex7 = 7'b1111001;
            4'h4:    hex7 = 7'b0110011;
            4'h5:    hex7 = 7'b1011011;
            4'h6:    hex7 = 7'b1011111;
            4'h7:    hex7 = 7'b1110000;
            4'h8:    hex7 = 7'b1111111;
            4'h9:    hex7 = 7'b1111011;
            4'hA:    hex7 = 7'b1110111;
            4'hB:    hex7 = 7'b0011111;
            4'hC:    hex7 = 7'b1001110;
            4'hD:    hex7 = 7'b0111101;
            4'hE:    hex7 = 7'b1001111;
            default: hex7 = 7'b1000111;
        endcase
    endfunction

    // upper_zero[i]: nibbles and points i..DIGITS-1 are all clear
    always_comb begin
        upper_zero = '0;
        zero_acc   = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_acc      = zero_acc && (shadow_val_q[4*i +: 4] == 4'h0) && !shadow_pt_q[i];
            upper_zero[i] = zero_acc;
        end
    end

    always_comb begin
        presc_wrap = &presc_q;
        boundary   = presc_wrap && (slot_q == LAST_SLOT);

        presc_d = presc_q + PRESCALE_LOG2'(1);
        slot_d  = slot_q;
        if (presc_wrap) begin
            slot_d = (slot_q == LAST_SLOT) ? '0 : slot_q + SLOT_W'(1);
        end
        frame_done_d = boundary;

        stage_val_d  = stage_val_q;
        stage_pt_d   = stage_pt_q;
        pending_d    = pending_q;
        shadow_val_d = shadow_val_q;
        shadow_pt_d  = shadow_pt_q;
        // A load landing on the boundary edge bypasses staging entirely
        if (boundary) begin
            pending_d = 1'b0;
            if (load) begin
                shadow_val_d = value;
                shadow_pt_d  = point;
            end else if (pending_q) begin
                shadow_val_d = stage_val_q;
                shadow_pt_d  = stage_pt_q;
            end
        end else if (load) begin
            stage_val_d = value;
            stage_pt_d  = point;
            pending_d   = 1'b1;
        end

        nibble    = shadow_val_q[{slot_q, 2'b00} +: 4];
        blank     = blank_lz && (slot_q != '0) && upper_zero[slot_q];
        presc_top = presc_q[PRESCALE_LOG2-1 -: BRIGHT_W];
        lit       = (&brightness) || (presc_top < brightness);

        segment_d = 8'hFF;
        digit_d   = 8'hFF;
        if (lit && !blank) begin
            segment_d = {~hex7(nibble), ~shadow_pt_q[slot_q]};
            digit_d   = ~(8'd1 << slot_q);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc_q      <= '0;
            slot_q       <= '0;
            frame_done_q <= 1'b0;
            stage_val_q  <= '0;
            stage_pt_q   <= '0;
            pending_q    <= 1'b0;
            shadow_val_q <= '0;
            shadow_pt_q  <= '0;
            segment_q    <= 8'hFF;
            digit_q      <= 8'hFF;
        end else begin
            presc_q      <= presc_d;
            slot_q       <= slot_d;
            frame_done_q <= frame_done_d;
            stage_val_q  <= stage_val_d;
            stage_pt_q   <= stage_pt_d;
            pending_q    <= pending_d;
            shadow_val_q <= shadow_val_d;
            shadow_pt_q  <= shadow_pt_d;
            segment_q    <= segment_d;
            digit_q      <= digit_d;
        end
    end

    assign segment    = segment_q;
    assign digit      = digit_q;
    assign frame_done = frame_done_q;

endmodule
